// File: rtl/demux1t16_32_reg.sv
// demux1t16_32_reg: routes one write word into one of 16 held slots
// (select s or auto pointer), valid/ready handshake, vld flags, clear sweep.
// Ports: clk, rst_n, i_data, s, auto, i_valid, i_ready, clr, busy,
//        wr_ack, ptr, vld, O0..O15.
module demux1t16_32_reg #(
   parameter int unsigned       WIDTH   = 32,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic [3:0]       s,
   input  logic             auto,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic             clr,
   output logic             busy,
   output logic             wr_ack,
   output logic [3:0]       ptr,
   output logic [15:0]      vld,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic [WIDTH-1:0] O4,
   output logic [WIDTH-1:0] O5,
   output logic [WIDTH-1:0] O6,
   output logic [WIDTH-1:0] O7,
   output logic [WIDTH-1:0] O8,
   output logic [WIDTH-1:0] O9,
   output logic [WIDTH-1:0] O10,
   output logic [WIDTH-1:0] O11,
   output logic [WIDTH-1:0] O12,
   output logic [WIDTH-1:0] O13,
   output logic [WIDTH-1:0] O14,
   output logic [WIDTH-1:0] O15
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [3:0]       ptr_q;
   logic [15:0]      vld_q;
   logic             ack_q;
   logic [WIDTH-1:0] slot_q [16];

   logic             we;
   logic [3:0]       tgt;

   // clr wins over a same-cycle write request
   assign i_ready = (state_q == IDLE) & ~clr;
   assign we      = i_valid & i_ready;
   assign tgt     = auto ? ptr_q : s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         vld_q   <= '0;
         ack_q   <= 1'b0;
         for (int k = 0; k < 16; k++) slot_q[k] <= CLR_VAL;
      end else begin
         unique case (state_q)
            IDLE: begin
               ack_q <= we;
               if (clr) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  ptr_q   <= '0;
               end else if (we) begin
                  slot_q[tgt] <= i_data;
                  vld_q[tgt]  <= 1'b1;
                  if (auto) ptr_q <= ptr_q + 4'd1;
               end
            end
            CLEAR: begin
               // one slot per cycle; clr here is ignored
               ack_q         <= 1'b0;
               slot_q[cnt_q] <= CLR_VAL;
               vld_q[cnt_q]  <= 1'b0;
               cnt_q         <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q == CLEAR);
   assign wr_ack = ack_q;
   assign ptr    = ptr_q;
   assign vld    = vld_q;

   assign O0  = slot_q[0];
   assign O1  = slot_q[1];
   assign O2  = slot_q[2];
   assign O3  = slot_q[3];
   assign O4  = slot_q[4];
   assign O5  = slot_q[5];
   assign O6  = slot_q[6];
   assign O7  = slot_q[7];
   assign O8  = slot_q[8];
   assign O9  = slot_q[9];
   assign O10 = slot_q[10];
   assign O11 = slot_q[11];
   assign O12 = slot_q[12];
   assign O13 = slot_q[13];
   assign O14 = slot_q[14];
   assign O15 = slot_q[15];

endmodule

// File: tb/tb_demux1t16_32_reg.sv
// tb_demux1t16_32_reg: directed bench for demux1t16_32_reg
// (single write, auto wrap, clear sweep, clr mid-sweep, async reset).
module tb_demux1t16_32_reg;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_data;
   logic [3:0]  s;
   logic        auto;
   logic        i_valid;
   logic        i_ready;
   logic        clr;
   logic        busy;
   logic        wr_ack;
   logic [3:0]  ptr;
   logic [15:0] vld;
   logic [31:0] o [16];

   int n_tot;
   int n_bad;

   demux1t16_32_reg dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (i_data),
      .s      (s),
      .auto   (auto),
      .i_valid(i_valid),
      .i_ready(i_ready),
      .clr    (clr),
      .busy   (busy),
      .wr_ack (wr_ack),
      .ptr    (ptr),
      .vld    (vld),
      .O0 (o[0]),  .O1 (o[1]),  .O2 (o[2]),  .O3 (o[3]),
      .O4 (o[4]),  .O5 (o[5]),  .O6 (o[6]),  .O7 (o[7]),
      .O8 (o[8]),  .O9 (o[9]),  .O10(o[10]), .O11(o[11]),
      .O12(o[12]), .O13(o[13]), .O14(o[14]), .O15(o[15])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tot   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      i_data  = '0;
      s       = '0;
      auto    = 1'b0;
      i_valid = 1'b0;
      clr     = 1'b0;

      // reset state
      #12;
      for (int k = 0; k < 16; k++) chk($sformatf("rst_O%0d", k), o[k], 0);
      chk("rst_vld", {16'h0, vld}, 0);
      chk("rst_ptr", {28'h0, ptr}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_ack", {31'h0, wr_ack}, 0);
      chk("rst_rdy", {31'h0, i_ready}, 1);
      rst_n = 1'b1;
      tick();

      // 1: single manual write
      s = 4'd5; auto = 1'b0; i_data = 32'hDEADBEEF; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk("t1_O5", o[5], 32'hDEADBEEF);
      chk("t1_O4", o[4], 0);
      chk("t1_O6", o[6], 0);
      chk("t1_vld", {16'h0, vld}, 32'h0020);
      chk("t1_ack", {31'h0, wr_ack}, 1);
      chk("t1_ptr", {28'h0, ptr}, 0);
      tick();
      chk("t1_ack_off", {31'h0, wr_ack}, 0);

      // 2: 17 auto writes, pointer wraps
      auto = 1'b1; i_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         i_data = 32'(i);
         tick();
         chk($sformatf("t2_ack%0d", i), {31'h0, wr_ack}, 1);
      end
      i_valid = 1'b0;
      chk("t2_O0", o[0], 16);
      for (int k = 1; k < 16; k++) chk($sformatf("t2_O%0d", k), o[k], 32'(k));
      chk("t2_ptr", {28'h0, ptr}, 1);
      chk("t2_vld", {16'h0, vld}, 32'hFFFF);

      // 3: clr with a same-cycle write; write held through sweep
      clr = 1'b1; i_valid = 1'b1; auto = 1'b0; s = 4'd3;
      i_data = 32'hAAAA5555;
      #1;
      chk("t3_rdy_clr", {31'h0, i_ready}, 0);
      tick();
      clr = 1'b0;
      chk("t3_ptr0", {28'h0, ptr}, 0);
      chk("t3_ack0", {31'h0, wr_ack}, 0);
      for (int j = 0; j < 16; j++) begin
         chk($sformatf("t3_busy%0d", j), {31'h0, busy}, 1);
         chk($sformatf("t3_rdy%0d", j), {31'h0, i_ready}, 0);
         chk($sformatf("t3_old%0d", j), o[j], (j == 0) ? 16 : 32'(j));
         tick();
         chk($sformatf("t3_clr%0d", j), o[j], 0);
         chk($sformatf("t3_vb%0d", j), {31'h0, vld[j]}, 0);
      end
      chk("t3_busy_end", {31'h0, busy}, 0);
      chk("t3_vld0", {16'h0, vld}, 0);
      chk("t3_ptr", {28'h0, ptr}, 0);
      chk("t3_rdy_end", {31'h0, i_ready}, 1);
      tick();
      i_valid = 1'b0;
      chk("t3_held_O3", o[3], 32'hAAAA5555);
      chk("t3_held_vld", {16'h0, vld}, 32'h0008);
      chk("t3_held_ack", {31'h0, wr_ack}, 1);

      // 4: clr again at cnt=7, no restart
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (7) tick();
      clr = 1'b1;
      #1;
      chk("t4_rdy_mid", {31'h0, i_ready}, 0);
      tick();
      clr = 1'b0;
      repeat (7) tick();
      chk("t4_busy15", {31'h0, busy}, 1);
      chk("t4_rdy15", {31'h0, i_ready}, 0);
      tick();
      chk("t4_busy16", {31'h0, busy}, 0);
      chk("t4_rdy16", {31'h0, i_ready}, 1);
      chk("t4_O3", o[3], 0);
      chk("t4_vld", {16'h0, vld}, 0);

      // 5: async reset at cnt=9
      s = 4'd9; i_data = 32'h12345678; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (9) tick();
      chk("t5_busy", {31'h0, busy}, 1);
      chk("t5_O9_pre", o[9], 32'h12345678);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_O9", o[9], 0);
      chk("t5_vld", {16'h0, vld}, 0);
      chk("t5_busy_rst", {31'h0, busy}, 0);
      chk("t5_rdy", {31'h0, i_ready}, 1);
      chk("t5_ptr", {28'h0, ptr}, 0);
      #2;
      rst_n = 1'b1;
      tick();
      s = 4'd2; i_data = 32'hCAFEF00D; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk("t5_O2", o[2], 32'hCAFEF00D);
      chk("t5_vld2", {16'h0, vld}, 32'h0004);
      chk("t5_ack", {31'h0, wr_ack}, 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
